if0_pcgen: RTL and testbench

IF0 stage of the front end: owns the fetch PC register and emits one fetch packet per cycle to IF1. A packet is up to two instructions from an 8-byte-aligned group.
- Each cycle it indexes the next-line predictor (NLP) with the current PC and consumes its per-slot predictions.
- It tracks MIPS delay slots, so a predicted-taken branch redirects only after its delay slot has been fetched.
- Redirects from IF3 and from the backend override everything.

---
 rtl/if0_pcgen_pkg.sv | 25 ++
 rtl/if0_pcgen_if.sv | 30 +++
 rtl/if0_pcgen_next_pc.sv | 58 +++++
 rtl/if0_pcgen.sv | 112 +++++++++++
 tb/tb_if0_pcgen.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/if0_pcgen_pkg.sv
// Shared front-end types: fetch packet, NLP prediction, IF0 state.
// Reused by the NLP and IF1 stages.
package if0_pcgen_pkg;

  localparam logic [31:0] RESET_PC = 32'hBFC0_0000;

  typedef enum logic {
    S_SEQ = 1'b0,
    S_DS  = 1'b1
  } state_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] target;
  } nlp_info_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [1:0]  slot_mask;
    logic [1:0]  pred_taken;
    logic [31:0] pred_target;
  } fetch_pkt_t;

endpackage

// File: rtl/if0_pcgen_if.sv
// IF0 -> IF1 fetch packet handshake.
// IF0 drives the packet, IF1 returns ready.
interface if0_pcgen_if;

  logic        if0_valid;
  logic [31:0] if0_pc;
  logic [1:0]  if0_slot_mask;
  logic [1:0]  if0_pred_taken;
  logic [31:0] if0_pred_target;
  logic        if1_ready;

  modport master (
    output if0_valid,
    output if0_pc,
    output if0_slot_mask,
    output if0_pred_taken,
    output if0_pred_target,
    input  if1_ready
  );

  modport slave (
    input  if0_valid,
    input  if0_pc,
    input  if0_slot_mask,
    input  if0_pred_taken,
    input  if0_pred_target,
    output if1_ready
  );

endinterface

// File: rtl/if0_pcgen_next_pc.sv
// IF0 next-PC logic: slot mask, taken-slot pick, and the PC/state
// to load when the current packet is accepted.
module if0_next_pc
  import if0_pcgen_pkg::*;
(
  input  logic [31:0] i_pc,
  input  state_t      i_state,
  input  logic [31:0] i_ds_target,
  input  nlp_info_t   i_nlp0,
  input  nlp_info_t   i_nlp1,
  output logic [1:0]  o_slot_mask,
  output logic [1:0]  o_pred_taken,
  output logic [31:0] o_pred_target,
  output logic [31:0] o_fire_pc,
  output state_t      o_fire_state,
  output logic        o_ds_load
);

  logic        w_mask2;
  logic        w_t0;
  logic        w_t1;
  logic [31:0] w_seq;

  assign w_mask2 = (i_state == S_SEQ) & ~i_pc[2];
  assign o_slot_mask = {w_mask2, 1'b1};

  assign w_seq = w_mask2 ? {i_pc[31:3] + 29'd1, 3'b000}
                         : i_pc + 32'd4;

  assign w_t0 = (i_state == S_SEQ) & i_nlp0.valid;
  assign w_t1 = w_mask2 & i_nlp1.valid & ~w_t0;
  assign o_pred_taken = {w_t1, w_t0};

  always_comb begin
    o_pred_target = '0;
    if (w_t0)
      o_pred_target = i_nlp0.target;
    else if (w_t1)
      o_pred_target = i_nlp1.target;
  end

  // A taken last slot must fetch its delay slot before jumping.
  always_comb begin
    o_fire_pc    = w_seq;
    o_fire_state = S_SEQ;
    o_ds_load    = 1'b0;
    unique case (1'b1)
      (i_state == S_DS): o_fire_pc = i_ds_target;
      (w_t0 & w_mask2):  o_fire_pc = i_nlp0.target;
      ((w_t0 & ~w_mask2) | w_t1): begin
        o_fire_state = S_DS;
        o_ds_load    = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/if0_pcgen.sv
// IF0 stage: fetch PC register, delay-slot tracking and redirects.
// Emits one packet of up to two instructions per cycle.
module if0_pcgen
  import if0_pcgen_pkg::*;
#(
  parameter logic [31:0] RESET_PC = if0_pcgen_pkg::RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] nlp_lookup_pc,
  input  logic        nlp0_valid,
  input  logic [31:0] nlp0_target,
  input  logic        nlp1_valid,
  input  logic [31:0] nlp1_target,
  input  logic        if3_redirect,
  input  logic [31:0] if3_target,
  input  logic        backend_redirect,
  input  logic [31:0] backend_target,
  if0_pcgen_if.master if1_if
);

  logic [31:0] r_pc;
  logic        r_valid;
  state_t      r_state;
  logic [31:0] r_ds_target;

  logic [31:0] w_pc_nxt;
  logic        w_valid_nxt;
  state_t      w_state_nxt;
  logic [31:0] w_ds_nxt;

  logic        w_fire;
  nlp_info_t   w_nlp0;
  nlp_info_t   w_nlp1;
  logic [1:0]  w_mask;
  logic [1:0]  w_taken;
  logic [31:0] w_target;
  logic [31:0] w_fire_pc;
  state_t      w_fire_state;
  logic        w_ds_load;
  fetch_pkt_t  w_pkt;

  assign w_nlp0 = '{valid: nlp0_valid, target: nlp0_target};
  assign w_nlp1 = '{valid: nlp1_valid, target: nlp1_target};
  assign w_fire = r_valid & if1_if.if1_ready;

  if0_next_pc u_next_pc (
    .i_pc          (r_pc),
    .i_state       (r_state),
    .i_ds_target   (r_ds_target),
    .i_nlp0        (w_nlp0),
    .i_nlp1        (w_nlp1),
    .o_slot_mask   (w_mask),
    .o_pred_taken  (w_taken),
    .o_pred_target (w_target),
    .o_fire_pc     (w_fire_pc),
    .o_fire_state  (w_fire_state),
    .o_ds_load     (w_ds_load)
  );

  // Redirects win over fire; the packet in flight is dropped.
  always_comb begin
    w_pc_nxt    = r_pc;
    w_valid_nxt = r_valid;
    w_state_nxt = r_state;
    w_ds_nxt    = r_ds_target;
    if (backend_redirect) begin
      w_pc_nxt    = backend_target;
      w_valid_nxt = 1'b1;
      w_state_nxt = S_SEQ;
    end else if (if3_redirect) begin
      w_pc_nxt    = if3_target;
      w_valid_nxt = 1'b1;
      w_state_nxt = S_SEQ;
    end else if (w_fire) begin
      w_pc_nxt    = w_fire_pc;
      w_state_nxt = w_fire_state;
      if (w_ds_load)
        w_ds_nxt = w_target;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc        <= RESET_PC;
      r_valid     <= 1'b1;
      r_state     <= S_SEQ;
      r_ds_target <= '0;
    end else begin
      r_pc        <= w_pc_nxt;
      r_valid     <= w_valid_nxt;
      r_state     <= w_state_nxt;
      r_ds_target <= w_ds_nxt;
    end
  end

  assign w_pkt = '{
    valid:       r_valid,
    pc:          r_pc,
    slot_mask:   w_mask,
    pred_taken:  w_taken,
    pred_target: w_target
  };

  assign nlp_lookup_pc          = r_pc;
  assign if1_if.if0_valid       = w_pkt.valid;
  assign if1_if.if0_pc          = w_pkt.pc;
  assign if1_if.if0_slot_mask   = w_pkt.slot_mask;
  assign if1_if.if0_pred_taken  = w_pkt.pred_taken;
  assign if1_if.if0_pred_target = w_pkt.pred_target;

endmodule

// File: tb/tb_if0_pcgen.sv
// Bench for if0_pcgen: directed fetch scenarios, then random traffic
// against a pending-branch-target reference model.
module tb_if0_pcgen;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] nlp_lookup_pc;
  logic        nlp0_valid;
  logic [31:0] nlp0_target;
  logic        nlp1_valid;
  logic [31:0] nlp1_target;
  logic        if3_redirect;
  logic [31:0] if3_target;
  logic        backend_redirect;
  logic [31:0] backend_target;

  int checks = 0;
  int failures = 0;

  if0_pcgen_if u_if ();

  if0_pcgen dut (
    .clk              (clk),
    .rst              (rst),
    .nlp_lookup_pc    (nlp_lookup_pc),
    .nlp0_valid       (nlp0_valid),
    .nlp0_target      (nlp0_target),
    .nlp1_valid       (nlp1_valid),
    .nlp1_target      (nlp1_target),
    .if3_redirect     (if3_redirect),
    .if3_target       (if3_target),
    .backend_redirect (backend_redirect),
    .backend_target   (backend_target),
    .if1_if           (u_if.master)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic chk_pkt(input string tag, input logic [31:0] pc,
                         input logic [1:0] mask, input logic [1:0] tk);
    chk({tag, ".pc"}, u_if.if0_pc, pc);
    chk({tag, ".mask"}, {30'd0, u_if.if0_slot_mask}, {30'd0, mask});
    chk({tag, ".taken"}, {30'd0, u_if.if0_pred_taken}, {30'd0, tk});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    nlp0_valid = 0; nlp0_target = '0;
    nlp1_valid = 0; nlp1_target = '0;
    if3_redirect = 0; if3_target = '0;
    backend_redirect = 0; backend_target = '0;
  endtask

  task automatic redir(input logic [31:0] t);
    backend_redirect = 1;
    backend_target = t;
    tick();
    clr();
  endtask

  // Steer to 80000000, predict slot1 taken -> now in delay slot.
  task automatic enter_ds();
    redir(32'h8000_0000);
    nlp1_valid = 1;
    nlp1_target = 32'h8000_2000;
    tick();
    clr();
  endtask

  function automatic logic [31:0] rnd_tgt();
    logic [31:0] v;
    v = $urandom;
    if ($urandom_range(0, 3) != 0) v[1:0] = 2'b00;
    if ($urandom_range(0, 15) == 0) v = 32'hFFFF_FFF0 | (v & 32'hF);
    return v;
  endfunction

  // Reference model state: fetch pc plus an optional pending branch
  // target waiting for its delay slot to be fetched.
  logic [31:0] m_pc;
  logic [31:0] m_pend[$];

  initial begin
    int nslots;
    int tk_slot;
    logic [31:0] tk_tgt;
    logic [1:0] e_mask;
    logic [1:0] e_tk;
    logic rdy;

    clr();
    rst = 1;
    u_if.if1_ready = 1;
    tick();
    chk("rst.valid", {31'd0, u_if.if0_valid}, 32'd1);
    chk_pkt("rst", 32'hBFC0_0000, 2'b11, 2'b00);
    chk("rst.lookup", nlp_lookup_pc, 32'hBFC0_0000);
    rst = 0;
    #1;
    chk_pkt("seq0", 32'hBFC0_0000, 2'b11, 2'b00);
    tick();
    chk_pkt("seq1", 32'hBFC0_0008, 2'b11, 2'b00);
    tick();
    chk_pkt("seq2", 32'hBFC0_0010, 2'b11, 2'b00);

    redir(32'h8000_0004);
    chk_pkt("br.odd", 32'h8000_0004, 2'b01, 2'b00);
    tick();
    chk_pkt("br.next", 32'h8000_0008, 2'b11, 2'b00);

    redir(32'h8000_0000);
    nlp0_valid = 1;
    nlp0_target = 32'h8000_1000;
    #1;
    chk_pkt("t0", 32'h8000_0000, 2'b11, 2'b01);
    chk("t0.tgt", u_if.if0_pred_target, 32'h8000_1000);
    tick();
    clr();
    #1;
    chk_pkt("t0.dst", 32'h8000_1000, 2'b11, 2'b00);
    chk("t0.tgt0", u_if.if0_pred_target, 32'h0);

    redir(32'h8000_0000);
    nlp1_valid = 1;
    nlp1_target = 32'h8000_2000;
    #1;
    chk_pkt("t1", 32'h8000_0000, 2'b11, 2'b10);
    chk("t1.tgt", u_if.if0_pred_target, 32'h8000_2000);
    tick();
    clr();
    nlp0_valid = 1;
    nlp0_target = 32'h1234_5678;
    #1;
    chk_pkt("t1.ds", 32'h8000_0008, 2'b01, 2'b00);
    chk("t1.ds.tgt", u_if.if0_pred_target, 32'h0);
    tick();
    clr();
    #1;
    chk_pkt("t1.dst", 32'h8000_2000, 2'b11, 2'b00);

    enter_ds();
    u_if.if1_ready = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk_pkt("stall", 32'h8000_0008, 2'b01, 2'b00);
      tick();
    end
    u_if.if1_ready = 1;
    #1;
    chk_pkt("stall.end", 32'h8000_0008, 2'b01, 2'b00);
    tick();
    chk_pkt("stall.dst", 32'h8000_2000, 2'b11, 2'b00);

    enter_ds();
    backend_redirect = 1; backend_target = 32'h8000_3000;
    if3_redirect = 1; if3_target = 32'h8000_4000;
    tick();
    clr();
    #1;
    chk_pkt("prio", 32'h8000_3000, 2'b11, 2'b00);
    tick();
    chk_pkt("prio.seq", 32'h8000_3008, 2'b11, 2'b00);

    redir(32'hFFFF_FFFC);
    chk_pkt("wrap", 32'hFFFF_FFFC, 2'b01, 2'b00);
    tick();
    chk_pkt("wrap.next", 32'h0000_0000, 2'b11, 2'b00);

    // Random phase, model synced by a reset cycle.
    rst = 1;
    tick();
    rst = 0;
    m_pc = 32'hBFC0_0000;
    m_pend.delete();
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 199) == 0);
      backend_redirect = ($urandom_range(0, 19) == 0);
      backend_target = rnd_tgt();
      if3_redirect = ($urandom_range(0, 19) == 0);
      if3_target = rnd_tgt();
      nlp0_valid = ($urandom_range(0, 3) == 0);
      nlp0_target = rnd_tgt();
      nlp1_valid = ($urandom_range(0, 2) == 0);
      nlp1_target = rnd_tgt();
      rdy = ($urandom_range(0, 3) != 0);
      u_if.if1_ready = rdy;
      #1;

      nslots = (m_pend.size() != 0 || m_pc % 8 >= 4) ? 1 : 2;
      e_mask = (nslots == 2) ? 2'b11 : 2'b01;
      tk_slot = -1;
      tk_tgt = 32'h0;
      if (m_pend.size() == 0) begin
        if (nlp0_valid) begin
          tk_slot = 0; tk_tgt = nlp0_target;
        end else if (nslots == 2 && nlp1_valid) begin
          tk_slot = 1; tk_tgt = nlp1_target;
        end
      end
      e_tk = (tk_slot < 0) ? 2'b00 : 2'(1 << tk_slot);

      chk("r.valid", {31'd0, u_if.if0_valid}, 32'd1);
      chk("r.lookup", nlp_lookup_pc, m_pc);
      chk_pkt("r", m_pc, e_mask, e_tk);
      chk("r.tgt", u_if.if0_pred_target, tk_tgt);

      if (rst) begin
        m_pc = 32'hBFC0_0000;
        m_pend.delete();
      end else if (backend_redirect) begin
        m_pc = backend_target;
        m_pend.delete();
      end else if (if3_redirect) begin
        m_pc = if3_target;
        m_pend.delete();
      end else if (rdy) begin
        if (m_pend.size() != 0) begin
          m_pc = m_pend.pop_front();
        end else if (tk_slot >= 0 && tk_slot < nslots - 1) begin
          m_pc = tk_tgt;
        end else begin
          m_pc = (nslots == 2) ? (m_pc & 32'hFFFF_FFF8) + 32'd8
                               : m_pc + 32'd4;
          if (tk_slot >= 0) m_pend.push_back(tk_tgt);
        end
      end
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
